// File: rtl/apb_fifo_pkg.sv
// Register map, field positions and FSM encoding shared by the APB FIFO register block.
package apb_fifo_pkg;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;
  localparam logic [3:0] ADDR_THRESH = 4'hC;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_UNF     = 3;
  localparam int ST_CNT_LSB = 8;

  localparam int CTRL_FLUSH  = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WAIT  = 2'd2
  } apb_state_e;

  function automatic logic [31:0] status_word(input logic       empty,
                                              input logic       full,
                                              input logic       ovf,
                                              input logic       unf,
                                              input logic [7:0] cnt);
    logic [31:0] w;
    w                   = '0;
    w[ST_EMPTY]         = empty;
    w[ST_FULL]          = full;
    w[ST_OVF]           = ovf;
    w[ST_UNF]           = unf;
    w[ST_CNT_LSB +: 8]  = cnt;
    return w;
  endfunction

endpackage

// File: rtl/apb_fifo_regs_sync_fifo.sv
// Synchronous FIFO with power-of-two depth; head entry is presented combinationally.
module sync_fifo
  import apb_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = 32,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  // Flush outranks any push or pop arriving on the same edge.
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      cnt <= cnt + CW'(1);
      else if (pop_ok && !push_ok) cnt <= cnt - CW'(1);
    end
  end

  // Storage is datapath only and carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/apb_fifo_regs.sv
// APB3/APB4 completer exposing a FIFO via DATA/STATUS/CTRL/THRESH registers.
// Build option: APB_FIFO_PPROT_CHK_EN rejects unprivileged CTRL/THRESH writes.
module apb_fifo_regs
  import apb_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = 32
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic [31:0]   PADDR,
  input  logic [2:0]    PPROT,
  input  logic          PSEL,
  input  logic          PENABLE,
  input  logic          PWRITE,
  input  logic [DW-1:0] PWDATA,
  input  logic [3:0]    PSTRB,
  output logic          PREADY,
  output logic [DW-1:0] PRDATA,
  output logic          PSLVERR,
  output logic          irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  apb_state_e    state;
  apb_state_e    state_d;
  logic [11:2]   addr_q;
  logic          write_q;
  logic          ovf;
  logic          unf;
  logic          irq_en;
  logic [7:0]    thresh;

  logic [CW-1:0] count;
  logic [DW-1:0] head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          flush;

  logic          set_ovf;
  logic          set_unf;
  logic          clr_ovf;
  logic          clr_unf;
  logic          ctrl_we;
  logic          thresh_we;
  logic          ready;
  logic          slverr;
  logic [DW-1:0] rdata;

  logic [3:0]    offset;
  logic          addr_ok;
  logic          is_data_rd;
  logic          access;
  logic          prot_ok;
  logic          irq_d;
  logic          unused_bits;

  assign offset     = {addr_q[3:2], 2'b00};
  assign addr_ok    = (addr_q[11:4] == '0);
  assign is_data_rd = !write_q && addr_ok && (offset == ADDR_DATA);
  assign access     = PSEL && PENABLE;

`ifdef APB_FIFO_PPROT_CHK_EN
  assign prot_ok = PPROT[0];
`else
  assign prot_ok = 1'b1;
`endif

  assign unused_bits = ^{PADDR[31:12], PADDR[1:0], PPROT};

  sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (PWDATA),
    .rdata (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d   = state;
    ready     = 1'b1;
    slverr    = 1'b0;
    rdata     = '0;
    push      = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    clr_ovf   = 1'b0;
    clr_unf   = 1'b0;
    ctrl_we   = 1'b0;
    thresh_we = 1'b0;
    case (state)
      IDLE: begin
        if (PSEL && !PENABLE) state_d = SETUP;
      end
      SETUP: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (PENABLE) begin
          if (is_data_rd) begin
            // DATA reads insert one wait state so the pop lands on the next edge.
            ready   = 1'b0;
            state_d = WAIT;
          end else begin
            state_d = IDLE;
            if (!addr_ok) begin
              slverr = 1'b1;
            end else if (write_q) begin
              case (offset)
                ADDR_DATA: begin
                  if (PSTRB != 4'hF) begin
                    slverr = 1'b1;
                  end else if (fifo_full) begin
                    slverr  = 1'b1;
                    set_ovf = 1'b1;
                  end else begin
                    push = 1'b1;
                  end
                end
                ADDR_STATUS: begin
                  clr_ovf = PWDATA[ST_OVF];
                  clr_unf = PWDATA[ST_UNF];
                end
                ADDR_CTRL: begin
                  if (!prot_ok) begin
                    slverr = 1'b1;
                  end else begin
                    ctrl_we = 1'b1;
                    flush   = PSTRB[0] && PWDATA[CTRL_FLUSH];
                  end
                end
                ADDR_THRESH: begin
                  if (!prot_ok) slverr = 1'b1;
                  else          thresh_we = 1'b1;
                end
                default: ;
              endcase
            end else begin
              case (offset)
                ADDR_STATUS: rdata = DW'(status_word(fifo_empty, fifo_full, ovf, unf, 8'(count)));
                ADDR_CTRL:   rdata[CTRL_IRQ_EN] = irq_en;
                ADDR_THRESH: rdata = DW'(thresh);
                default:     rdata = '0;
              endcase
            end
          end
        end
      end
      WAIT: begin
        state_d = IDLE;
        if (access) begin
          if (fifo_empty) begin
            slverr  = 1'b1;
            set_unf = 1'b1;
          end else begin
            rdata = head;
            pop   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign irq_d = irq_en && (9'(count) >= 9'(thresh)) && (thresh != '0);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      irq_en  <= 1'b0;
      thresh  <= '0;
      irq     <= 1'b0;
    end else begin
      state <= state_d;
      if (state == IDLE && PSEL && !PENABLE) begin
        addr_q  <= PADDR[11:2];
        write_q <= PWRITE;
      end
      if (set_ovf)      ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
      if (set_unf)      unf <= 1'b1;
      else if (clr_unf) unf <= 1'b0;
      if (ctrl_we && PSTRB[0])   irq_en <= PWDATA[CTRL_IRQ_EN];
      if (thresh_we && PSTRB[0]) thresh <= PWDATA[7:0];
      irq <= irq_d;
    end
  end

  assign PREADY  = ready;
  assign PRDATA  = rdata;
  assign PSLVERR = slverr;

endmodule

// File: tb/tb_apb_fifo_regs.sv
// Self-checking bench for apb_fifo_regs: vector table, directed corner cases, randomized model run.
module tb_apb_fifo_regs;

  localparam int DEPTH = 16;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [31:0] PADDR;
  logic [2:0]  PPROT;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;
  logic        irq;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 PCLK = ~PCLK;

  apb_fifo_regs #(.DEPTH(DEPTH), .DW(32)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PADDR   (PADDR),
    .PPROT   (PPROT),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PSTRB   (PSTRB),
    .PREADY  (PREADY),
    .PRDATA  (PRDATA),
    .PSLVERR (PSLVERR),
    .irq     (irq)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;   // write data, or expected read data
    logic [3:0]  strb;
    logic        err;
    int          waits;
  } vec_t;

  vec_t tbl[$];

  // Reference model state
  logic [31:0] mq[$];
  logic        m_ovf, m_unf, m_irq_en;
  logic [7:0]  m_thresh;

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[0] = (mq.size() == 0);
    s[1] = (mq.size() == DEPTH);
    s[2] = m_ovf;
    s[3] = m_unf;
    s[15:8] = 8'(mq.size());
    return s;
  endfunction

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot,
                          output logic [31:0] rd, output logic err, output int waits);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
    PWDATA = wdata; PSTRB = strb; PPROT = prot;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits = 0;
    #1;
    while (!PREADY && waits < 8) begin
      @(posedge PCLK); #2;
      waits++;
    end
    rd  = PRDATA;
    err = PSLVERR;
    if (!PREADY) begin
      n_vec++; n_miss++;
      $display("FAIL pready_timeout: PREADY=%0b after %0d waits, required 1", PREADY, waits);
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic check_xfer(input string name, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                            input logic exp_err, input logic [31:0] exp_data, input int exp_w);
    logic [31:0] rd;
    logic        err;
    int          w;
    apb_xfer(wr, addr, wdata, strb, prot, rd, err, w);
    n_vec++;
    if (err !== exp_err || (!wr && rd !== exp_data) || w != exp_w) begin
      n_miss++;
      $display("FAIL %s: got err=%0b data=0x%08h waits=%0d, required err=%0b data=0x%08h waits=%0d",
               name, err, rd, w, exp_err, wr ? rd : exp_data, exp_w);
    end
  endtask

  task automatic wr_chk(input string name, input logic [31:0] addr, input logic [31:0] d,
                        input logic [3:0] strb, input logic exp_err);
    check_xfer(name, 1'b1, addr, d, strb, 3'b001, exp_err, 32'h0, 0);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp_d,
                        input logic exp_err, input int exp_w);
    check_xfer(name, 1'b0, addr, 32'h0, 4'hF, 3'b001, exp_err, exp_d, exp_w);
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr, wd, e_data;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic        wr, e_err, priv_bad;
    int          kind, e_w;

    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = 4'hF; PPROT = 3'b001;
    repeat (3) @(posedge PCLK);
    #1;
    check_val("rst_pready",  32'(PREADY),  32'd1);
    check_val("rst_pslverr", 32'(PSLVERR), 32'd0);
    check_val("rst_prdata",  PRDATA,       32'd0);
    check_val("rst_irq",     32'(irq),     32'd0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // ---------------- table-driven vectors ----------------
    tbl.push_back('{1'b0, 32'h0000_0004, 32'h0000_0001, 4'hF, 1'b0, 0});
    tbl.push_back('{1'b0, 32'h0000_0008, 32'h0000_0000, 4'hF, 1'b0, 0});
    tbl.push_back('{1'b0, 32'h0000_000C, 32'h0000_0000, 4'hF, 1'b0, 0});
    tbl.push_back('{1'b1, 32'h0000_0000, 32'hA5A5_0001, 4'hF, 1'b0, 0});
    tbl.push_back('{1'b1, 32'h0000_0000, 32'hA5A5_0002, 4'hF, 1'b0, 0});
    tbl.push_back('{1'b1, 32'h0000_0000, 32'hA5A5_0003, 4'hF, 1'b0, 0});
    tbl.push_back('{1'b0, 32'h0000_0004, 32'h0000_0300, 4'hF, 1'b0, 0});
    tbl.push_back('{1'b0, 32'h0000_0000, 32'hA5A5_0001, 4'hF, 1'b0, 1});
    tbl.push_back('{1'b0, 32'h0000_0004, 32'h0000_0200, 4'hF, 1'b0, 0});
    tbl.push_back('{1'b0, 32'h0000_0000, 32'hA5A5_0002, 4'hF, 1'b0, 1});
    tbl.push_back('{1'b0, 32'hABCD_E004, 32'h0000_0100, 4'hF, 1'b0, 0});
    tbl.push_back('{1'b0, 32'h0000_0000, 32'hA5A5_0003, 4'hF, 1'b0, 1});
    tbl.push_back('{1'b0, 32'h0000_0004, 32'h0000_0001, 4'hF, 1'b0, 0});
    tbl.push_back('{1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 4'h3, 1'b1, 0});
    tbl.push_back('{1'b0, 32'h0000_0004, 32'h0000_0001, 4'hF, 1'b0, 0});
    tbl.push_back('{1'b1, 32'h0000_0010, 32'h0000_0001, 4'hF, 1'b1, 0});
    tbl.push_back('{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 1'b1, 0});
    tbl.push_back('{1'b0, 32'h0000_0007, 32'h0000_0001, 4'hF, 1'b0, 0});
    tbl.push_back('{1'b1, 32'h0000_000C, 32'h0000_1234, 4'h1, 1'b0, 0});
    tbl.push_back('{1'b0, 32'h0000_000C, 32'h0000_0034, 4'hF, 1'b0, 0});
    tbl.push_back('{1'b1, 32'h0000_000C, 32'hFFFF_FF00, 4'hE, 1'b0, 0});
    tbl.push_back('{1'b0, 32'h0000_000C, 32'h0000_0034, 4'hF, 1'b0, 0});
    tbl.push_back('{1'b1, 32'h0000_000C, 32'h0000_0000, 4'hF, 1'b0, 0});
    tbl.push_back('{1'b0, 32'h0000_000C, 32'h0000_0000, 4'hF, 1'b0, 0});
    tbl.push_back('{1'b1, 32'h0000_0008, 32'h0000_0003, 4'hF, 1'b0, 0});
    tbl.push_back('{1'b0, 32'h0000_0008, 32'h0000_0002, 4'hF, 1'b0, 0});
    tbl.push_back('{1'b1, 32'h0000_0008, 32'h0000_0000, 4'hF, 1'b0, 0});
    tbl.push_back('{1'b0, 32'h0000_0008, 32'h0000_0000, 4'hF, 1'b0, 0});
    tbl.push_back('{1'b1, 32'h0000_0100, 32'h0000_0005, 4'hF, 1'b1, 0});
    tbl.push_back('{1'b0, 32'h0000_0004, 32'h0000_0001, 4'hF, 1'b0, 0});
    for (int i = 0; i < tbl.size(); i++) begin
      check_xfer($sformatf("tbl[%0d]", i), tbl[i].wr, tbl[i].addr, tbl[i].data,
                 tbl[i].strb, 3'b001, tbl[i].err, tbl[i].data, tbl[i].waits);
    end

    // ---------------- overflow and W1C ----------------
    for (int i = 0; i < DEPTH; i++) wr_chk("fill", 32'h0, 32'hB000_0000 + 32'(i), 4'hF, 1'b0);
    wr_chk("ovf_write", 32'h0, 32'hB000_00FF, 4'hF, 1'b1);
    rd_chk("ovf_status", 32'h4, 32'h0000_1006, 1'b0, 0);
    wr_chk("ovf_w1c", 32'h4, 32'h0000_0004, 4'hF, 1'b0);
    rd_chk("ovf_cleared", 32'h4, 32'h0000_1002, 1'b0, 0);
    rd_chk("full_head", 32'h0, 32'hB000_0000, 1'b0, 1);
    rd_chk("after_pop", 32'h4, 32'h0000_0F00, 1'b0, 0);
    wr_chk("flush", 32'h8, 32'h0000_0001, 4'hF, 1'b0);
    rd_chk("flushed", 32'h4, 32'h0000_0001, 1'b0, 0);

    // ---------------- underflow ----------------
    rd_chk("unf_read", 32'h0, 32'h0, 1'b1, 1);
    rd_chk("unf_status", 32'h4, 32'h0000_0009, 1'b0, 0);
    wr_chk("unf_w1c", 32'h4, 32'h0000_0008, 4'hF, 1'b0);
    rd_chk("unf_cleared", 32'h4, 32'h0000_0001, 1'b0, 0);

    // ---------------- threshold interrupt ----------------
    wr_chk("thr4", 32'hC, 32'h4, 4'hF, 1'b0);
    wr_chk("irq_en", 32'h8, 32'h2, 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) wr_chk("irq_push", 32'h0, 32'hC000_0000 + 32'(i), 4'hF, 1'b0);
    @(posedge PCLK); #1;
    check_val("irq_below", 32'(irq), 32'd0);
    wr_chk("irq_push4", 32'h0, 32'hC000_0003, 4'hF, 1'b0);
    check_val("irq_lag", 32'(irq), 32'd0);
    @(posedge PCLK); #1;
    check_val("irq_rise", 32'(irq), 32'd1);
    wr_chk("irq_flush", 32'h8, 32'h3, 4'hF, 1'b0);
    check_val("irq_hold", 32'(irq), 32'd1);
    @(posedge PCLK); #1;
    check_val("irq_fall", 32'(irq), 32'd0);
    rd_chk("irq_status", 32'h4, 32'h0000_0001, 1'b0, 0);
    rd_chk("irq_ctrl", 32'h8, 32'h0000_0002, 1'b0, 0);
    wr_chk("ctrl0", 32'h8, 32'h0, 4'hF, 1'b0);
    wr_chk("thr0", 32'hC, 32'h0, 4'hF, 1'b0);

    // ---------------- PPROT handling ----------------
`ifdef APB_FIFO_PPROT_CHK_EN
    check_xfer("prot_ctrl", 1'b1, 32'h8, 32'h2, 4'hF, 3'b000, 1'b1, 32'h0, 0);
    rd_chk("prot_ctrl_rd", 32'h8, 32'h0, 1'b0, 0);
    check_xfer("prot_thr", 1'b1, 32'hC, 32'h7, 4'hF, 3'b010, 1'b1, 32'h0, 0);
    rd_chk("prot_thr_rd", 32'hC, 32'h0, 1'b0, 0);
`else
    check_xfer("prot_ctrl", 1'b1, 32'h8, 32'h2, 4'hF, 3'b000, 1'b0, 32'h0, 0);
    rd_chk("prot_ctrl_rd", 32'h8, 32'h2, 1'b0, 0);
    check_xfer("prot_thr", 1'b1, 32'hC, 32'h7, 4'hF, 3'b010, 1'b0, 32'h0, 0);
    rd_chk("prot_thr_rd", 32'hC, 32'h7, 1'b0, 0);
    wr_chk("prot_restore_c", 32'h8, 32'h0, 4'hF, 1'b0);
    wr_chk("prot_restore_t", 32'hC, 32'h0, 4'hF, 1'b0);
`endif
    check_xfer("prot_data", 1'b1, 32'h0, 32'hD000_0001, 4'hF, 3'b000, 1'b0, 32'h0, 0);

    // ---------------- reset during DATA read wait state ----------------
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0; PPROT = 3'b001;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1;
    check_val("rd_first_cycle_pready", 32'(PREADY), 32'd0);
    @(posedge PCLK); #1;
    check_val("rd_wait_pready", 32'(PREADY), 32'd1);
    check_val("rd_wait_data", PRDATA, 32'hD000_0001);
    PRESETn = 1'b0;
    #1;
    check_val("rstw_pready",  32'(PREADY),  32'd1);
    check_val("rstw_pslverr", 32'(PSLVERR), 32'd0);
    check_val("rstw_prdata",  PRDATA,       32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    rd_chk("rstw_status", 32'h4, 32'h0000_0001, 1'b0, 0);

    // ---------------- randomized run against behavioural model ----------------
    mq.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_irq_en = 1'b0; m_thresh = '0;
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 11);
      if (i >= 200 && kind <= 2) kind = 4;
      prot = 3'($urandom_range(0, 7));
`ifdef APB_FIFO_PPROT_CHK_EN
      priv_bad = !prot[0];
`else
      priv_bad = 1'b0;
`endif
      addr = $urandom;
      addr[11:4] = '0;
      wd = $urandom;
      strb = 4'hF; wr = 1'b0; e_err = 1'b0; e_data = '0; e_w = 0;
      case (kind)
        0, 1, 2, 3: begin
          wr = 1'b1; addr[3:2] = 2'd0;
          if ($urandom_range(0, 9) == 0) strb = 4'($urandom_range(0, 14));
          if (strb != 4'hF) e_err = 1'b1;
          else if (mq.size() == DEPTH) begin e_err = 1'b1; m_ovf = 1'b1; end
          else mq.push_back(wd);
        end
        4, 5: begin
          addr[3:2] = 2'd0; e_w = 1;
          if (mq.size() == 0) begin e_err = 1'b1; m_unf = 1'b1; end
          else e_data = mq.pop_front();
        end
        6: begin
          addr[3:2] = 2'd1; e_data = exp_status();
        end
        7: begin
          wr = 1'b1; addr[3:2] = 2'd1;
          if (wd[2]) m_ovf = 1'b0;
          if (wd[3]) m_unf = 1'b0;
        end
        8: begin
          wr = 1'b1; addr[3:2] = 2'd3;
          wd = (wd & 32'hFFFF_FF00) | 32'($urandom_range(0, 20));
          strb = 4'($urandom);
          if (priv_bad) e_err = 1'b1;
          else if (strb[0]) m_thresh = wd[7:0];
        end
        9: begin
          wr = 1'b1; addr[3:2] = 2'd2;
          wd[0] = ($urandom_range(0, 5) == 0);
          strb = 4'($urandom);
          if (priv_bad) e_err = 1'b1;
          else if (strb[0]) begin
            m_irq_en = wd[1];
            if (wd[0]) mq.delete();
          end
        end
        10: begin
          addr[3:2] = ($urandom_range(0, 1) == 1) ? 2'd2 : 2'd3;
          e_data = (addr[3:2] == 2'd3) ? 32'(m_thresh) : {30'd0, m_irq_en, 1'b0};
        end
        default: begin
          addr[11:4] = 8'($urandom_range(1, 255));
          wr = 1'($urandom_range(0, 1));
          e_err = 1'b1;
        end
      endcase
      check_xfer($sformatf("rand[%0d] kind%0d", i, kind), wr, addr, wd, strb, prot, e_err, e_data, e_w);
      @(posedge PCLK); #1;
      check_val($sformatf("rand_irq[%0d]", i), 32'(irq),
                32'(m_irq_en && (mq.size() >= int'(m_thresh)) && (m_thresh != 0)));
    end
    rd_chk("rand_final_status", 32'h4, exp_status(), 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
